// File: rtl/pergate_compute_gatefn_mp_pkg.sv
// pergate_compute_gatefn_mp_pkg: shared field width, prime, gate-function codes and evaluator
package pergate_compute_gatefn_mp_pkg;
   localparam int F_NBITS = 16;
   localparam logic [F_NBITS-1:0] PRIME = 16'd65521;
   localparam int GATEFN_BITS = 1;
   localparam logic [GATEFN_BITS-1:0] GATEFN_ADD = 1'b0;
   localparam logic [GATEFN_BITS-1:0] GATEFN_MUL = 1'b1;
   localparam int UNIT_LAT = 2;
   function automatic logic [F_NBITS-1:0] gate_eval(input logic [GATEFN_BITS-1:0] fn, input logic [F_NBITS-1:0] a,
                                                    input logic [F_NBITS-1:0] b);
      logic [F_NBITS:0] s;
      logic [2*F_NBITS-1:0] m;
      s = {1'b0, a} + {1'b0, b};
      m = ({{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b}) % {{F_NBITS{1'b0}}, PRIME};
      return fn == GATEFN_MUL ? F_NBITS'(m) : (s >= {1'b0, PRIME} ? F_NBITS'(s - {1'b0, PRIME}) : s[F_NBITS-1:0]);
   endfunction
endpackage

// File: rtl/computation_gatefn.sv
// computation_gatefn: one field gate evaluation, result and ready UNIT_LAT cycles after en
module computation_gatefn
   import pergate_compute_gatefn_mp_pkg::*;
#(
   parameter logic [GATEFN_BITS-1:0] gate_fn = GATEFN_ADD
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               en,
   input  logic               mux_sel,
   input  logic [F_NBITS-1:0] in0,
   input  logic [F_NBITS-1:0] in1,
   output logic [F_NBITS-1:0] out,
   output logic               ready
);
   logic [1:0] cnt_q, cnt_d;
   logic [F_NBITS-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
   // mux_sel=1 combines in0 with itself instead of with in1
   always_comb begin
      cnt_d = en ? 2'(UNIT_LAT) : cnt_q - {1'b0, |cnt_q};
      a_d = en ? in0 : a_q;
      b_d = en ? (mux_sel ? in0 : in1) : b_q;
      out_d = cnt_q == 2'd1 ? gate_eval(gate_fn, a_q, b_q) : out_q;
   end
   always_ff @(posedge clk or negedge rstb)
      if (!rstb) begin
         cnt_q <= '0;
         a_q <= '0;
         b_q <= '0;
         out_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         a_q <= a_d;
         b_q <= b_d;
         out_q <= out_d;
      end
   assign out = out_q;
   assign ready = cnt_q == 2'd0;
endmodule

// File: rtl/pergate_compute_gatefn_mp.sv
// pergate_compute_gatefn_mp: evaluates NPTS gate points in rounds over NUNITS shared units
module pergate_compute_gatefn_mp
   import pergate_compute_gatefn_mp_pkg::*;
#(
   parameter logic [GATEFN_BITS-1:0] gate_fn = GATEFN_ADD,
   parameter int NPTS = 3,
   parameter int NUNITS = 1
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic                      en,
   input  logic                      mux_sel,
   input  logic [F_NBITS*NPTS-1:0]   in0,
   input  logic [F_NBITS*NPTS-1:0]   in1,
   output logic                      ready,
   output logic                      ready_pulse,
   output logic [F_NBITS*NPTS-1:0]   gatefn
);
   localparam int R = (NPTS + NUNITS - 1) / NUNITS;
   localparam int RW = R > 1 ? $clog2(R) : 1;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state_q, state_d;
   logic [RW-1:0] rnd_q, rnd_d;
   logic [F_NBITS*NPTS-1:0] op0_q, op0_d, op1_q, op1_d, gatefn_q, gatefn_d;
   logic sel_q, sel_d;
   logic [NUNITS-1:0] u_en, u_act, u_rdy;
   logic [NUNITS-1:0][F_NBITS-1:0] u_a, u_b, u_out;
   // unit k serves point rnd*NUNITS+k; units past the last point sit idle
   for (genvar k = 0; k < NUNITS; k++) begin : g_unit
      int p;
      assign p = int'(rnd_q) * NUNITS + k;
      assign u_act[k] = p < NPTS;
      assign u_a[k] = u_act[k] ? op0_q[p*F_NBITS +: F_NBITS] : '0;
      assign u_b[k] = u_act[k] ? op1_q[p*F_NBITS +: F_NBITS] : '0;
      computation_gatefn #(.gate_fn(gate_fn)) u_cg (
         .clk(clk),
         .rstb(rstb),
         .en(u_en[k]),
         .mux_sel(sel_q),
         .in0(u_a[k]),
         .in1(u_b[k]),
         .out(u_out[k]),
         .ready(u_rdy[k])
      );
   end
   always_comb begin
      state_d = state_q;
      rnd_d = rnd_q;
      op0_d = op0_q;
      op1_d = op1_q;
      sel_d = sel_q;
      gatefn_d = gatefn_q;
      u_en = '0;
      case (state_q)
         IDLE:
            if (en) begin
               op0_d = in0;
               op1_d = in1;
               sel_d = mux_sel;
               rnd_d = '0;
               state_d = ISSUE;
            end
         ISSUE: begin
            u_en = u_act;
            state_d = WAIT;
         end
         WAIT:
            if (&(u_rdy | ~u_act)) begin
               for (int k = 0; k < NUNITS; k++)
                  if (u_act[k]) gatefn_d[(int'(rnd_q)*NUNITS + k)*F_NBITS +: F_NBITS] = u_out[k];
               rnd_d = rnd_q + RW'(1);
               state_d = int'(rnd_q) == R - 1 ? DONE : ISSUE;
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstb)
      if (!rstb) begin
         state_q <= IDLE;
         rnd_q <= '0;
         op0_q <= '0;
         op1_q <= '0;
         sel_q <= 1'b0;
         gatefn_q <= '0;
      end else begin
         state_q <= state_d;
         rnd_q <= rnd_d;
         op0_q <= op0_d;
         op1_q <= op1_d;
         sel_q <= sel_d;
         gatefn_q <= gatefn_d;
      end
   assign ready = state_q == IDLE;
   assign ready_pulse = state_q == DONE;
   assign gatefn = gatefn_q;
endmodule

// File: doc/pergate_compute_gatefn_mp.md
PERGATE_COMPUTE_GATEFN_MP -- requirements
Module: pergate_compute_gatefn_mp

Interface
REQ-001 Parameter gate_fn, default 0, meaning GATEFN_BITS-wide gate function selector (add or mul) forwarded to every unit.
REQ-002 Parameter NPTS, default 3, meaning number of evaluation points V(0)..V(NPTS-1); legal range 1..16.
REQ-003 Parameter NUNITS, default 1, meaning number of physical computation_gatefn instances; legal range 1..NPTS.
REQ-004 clk  input  1  meaning system clock; the design SHALL use one clock, clk.
REQ-005 rstb  input  1  meaning asynchronous active-low reset.
REQ-006 en  input  1  meaning start request; sampled only when idle.
REQ-007 mux_sel  input  1  meaning operand select forwarded to units; latched at start.
REQ-008 in0  input  F_NBITS x NPTS  meaning left operands per point.
REQ-009 in1  input  F_NBITS x NPTS  meaning right operands per point.
REQ-010 ready  output  1  meaning idle, with results valid if at least one run has completed.
REQ-011 ready_pulse  output  1  meaning one-cycle strobe on run completion.
REQ-012 gatefn  output  F_NBITS x NPTS  meaning registered results per point.

Function
REQ-013 Points SHALL be processed in R = ceil(NPTS/NUNITS) rounds; round r uses unit k for point r*NUNITS+k, with nonexistent points in the last round left idle.
REQ-014 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-015 IDLE with en=1 SHALL latch in0, in1 and mux_sel into operand registers, clear the round counter, and go to ISSUE; ready SHALL drop the next cycle.
REQ-016 ISSUE SHALL drive en high for exactly one cycle to every active unit of the current round, then go to WAIT.
REQ-017 WAIT SHALL remain until every active unit reports ready, then capture unit outputs into gatefn[r*NUNITS+k].
REQ-018 On that same capture, the FSM SHALL increment the round counter and go to ISSUE if rounds remain, else go to DONE.
REQ-019 DONE SHALL last one cycle, assert ready_pulse in that cycle, and return to IDLE with ready=1.
REQ-020 Latency from en accept to ready_pulse SHALL be R*(2+Lu) cycles, where Lu is unit latency after its en.
REQ-021 en while not IDLE SHALL be ignored (no queueing); en in the DONE cycle SHALL be ignored; en in the first IDLE cycle after DONE SHALL be accepted.
REQ-022 Input changes after accept SHALL NOT affect results; gatefn entries SHALL hold until overwritten by the next run's capture.
REQ-023 ready_pulse SHALL never assert for two consecutive cycles, nor after reset without a run.
REQ-024 Arithmetic SHALL be mod the field prime via the units; no width growth; outputs are F_NBITS.
REQ-025 NUNITS=NPTS SHALL behave as fully parallel (R=1), functionally equal to the 3-instance predecessor when NPTS=3.

Reset
REQ-026 rstb low SHALL asynchronously force: FSM=IDLE, ready=1, ready_pulse=0, gatefn all 0, round counter 0, operand registers 0.
REQ-027 Reset asserted mid-run SHALL abort the run and also reset all units; no ready_pulse SHALL follow release.
REQ-028 The first en after reset release SHALL be accepted on the first rising edge with rstb high.

Structure
REQ-029 F_NBITS, GATEFN_BITS and gate-function codes SHALL come from the shared field/gatefn definitions; FSM state encoding SHALL be local.
REQ-030 The block SHALL instantiate NUNITS copies of the existing computation_gatefn sub-module and contain no arithmetic of its own.
REQ-031 Round counter width SHALL be clog2(R) with a minimum of 1; operand mux per unit SHALL be indexed by round counter.

Verification
REQ-032 Add, NPTS=3, NUNITS=3: in0={3,5,p-1}, in1={4,6,2} -> gatefn={7,11,1}, a single ready_pulse, latency 2+Lu.
REQ-033 Mul, NPTS=3, NUNITS=1: in0={2,p-1,0}, in1={9,p-1,7} -> gatefn={18,1,0}, latency 3*(2+Lu).
REQ-034 Mul, NPTS=5, NUNITS=2: in0={1,2,3,4,5} and in1={1,2,3,4,5} -> {1,4,9,16,25}; last round uses one unit only.
REQ-035 Second en mid-run plus input change after accept -> results are from the first operands; no extra run occurs.
REQ-036 Reset pulsed during WAIT in round 1 -> outputs 0 and ready=1 with no pulse; a following run with add {1,1,1}+{1,1,1} -> {2,2,2}.
